alt_run_detector: RTL and testbench
===================================

// Module: alt_run_detector
// PURPOSE
//  Parametrised serial alternating-run detector for the FSM-problems library.
//  Tracks the length of the current run of alternating bits (0101.. / 1010..) on a
//  qualified serial stream. Flags a hit when the run reaches MIN_RUN bits, in overlap or
//  non-overlap mode, and keeps a saturating hit counter and a sticky flag.
// PARAMETERS
//  MIN_RUN  3   alternating bits needed for a hit; legal range 2 .. 2**RUN_W-1
//  RUN_W    8   width of run_len; run_len saturates at 2**RUN_W-1
//  CNT_W    16  width of hit_count; hit_count saturates at 2**CNT_W-1
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      asynchronous, active-high; clears all state
//  din_valid  in   1      din is accepted on this rising edge when high
//  din        in   1      serial data bit
//  overlap_en in   1      1 = overlapping hits, 0 = non-overlapping; sampled with each accepted bit
//  clr        in   1      synchronous clear of hit_count and sticky
//  hit        out  1      registered one-cycle pulse per detection
//  run_len    out  RUN_W  length of current alternating run ending at last accepted bit
//  last_bit   out  1      last accepted bit
//  hit_count  out  CNT_W  number of hits since reset/clr, saturating
//  sticky     out  1      set by any hit, held until clr/reset
// BEHAVIOUR
//  - Reset (async): state=IDLE; hit, run_len, last_bit, hit_count, sticky all 0.
//  - FSM: IDLE (no reference bit), RUN (last_bit valid). Updates occur only on edges with din_valid=1.
//  - din_valid=0: no state change; hit=0 on the next cycle; other outputs hold.
//  - IDLE + accepted bit: last_bit<=din, run_len<=1, go RUN. No hit possible.
//  - RUN + accepted bit: last_bit<=din.
//    - din!=last_bit: run_len<=sat(run_len+1).
//    - din==last_bit: run_len<=1.
//  - Hit conditions, evaluated on the new run_len:
//    - overlap_en=1: hit when new run_len >= MIN_RUN. The state stays RUN, so every further
//      alternating bit hits again.
//    - overlap_en=0: hit when new run_len == MIN_RUN. Then run_len<=MIN_RUN and state<=IDLE,
//      so the next accepted bit starts a fresh run at 1 with no comparison.
//  - Latency: hit, run_len and last_bit update on the same edge that accepts the bit.
//    hit is high for exactly that one following cycle. There is no combinational path from din.
//  - run_len saturates at 2**RUN_W-1 and does not wrap. In overlap mode hits continue while
//    saturated and alternating.
//  - On hit: hit_count<=sat(hit_count+1) and sticky<=1.
//  - clr=1: hit_count<=0 and sticky<=0. clr wins over a same-cycle hit: the hit still pulses
//    but is not counted and does not set sticky. clr does not affect run_len, last_bit or state.
//  - overlap_en changing mid-run takes effect on the next accepted bit. Switching to
//    non-overlap with run_len > MIN_RUN gives no hit until a run is rebuilt, because == is required.
//  - Reset mid-run: immediate return to reset values; the first bit after release gives run_len=1.
// TESTING
//  1. MIN_RUN=3, overlap=1, valid every cycle, din 0,1,0,1,1
//     -> run_len 1,2,3,4,1; hit on bits 3,4; hit_count=2; sticky=1.
//  2. MIN_RUN=3, overlap=0, din 0,1,0,1,0,1
//     -> run_len 1,2,3,1,2,3; hit on bits 3,6; hit_count=2.
//  3. din_valid gaps: valid bits 1,0,1 with 2 idle cycles between each
//     -> outputs frozen during gaps, hit=0 in gaps; hit on 3rd valid bit only.
//  4. RUN_W=3, overlap=1, 10 alternating bits
//     -> run_len saturates at 7 (never wraps to 0); hit on bits 3..10; hit_count=8.
//  5. clr asserted on the edge of a hit with hit_count=5
//     -> hit=1, hit_count=0, sticky=0; next hit gives hit_count=1.
//  6. Async reset mid-edge after bits 1,0 (run_len=2)
//     -> all outputs 0 without a clock; then din 1 -> run_len=1, hit=0.

Source files
------------

// File: rtl/alt_run_detector.sv
// Serial alternating-run detector: tracks the current 0101../1010.. run length on a
// qualified bit stream and flags hits at MIN_RUN bits, in overlap or non-overlap mode.
module alt_run_detector #(
  parameter int MIN_RUN = 3,
  parameter int RUN_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din,
  input  logic             overlap_en,
  input  logic             clr,
  output logic             hit,
  output logic [RUN_W-1:0] run_len,
  output logic             last_bit,
  output logic [CNT_W-1:0] hit_count,
  output logic             sticky
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] MIN_LEN = RUN_W'(MIN_RUN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [RUN_W-1:0] run_inc;
  logic [RUN_W-1:0] len_next;
  logic             hit_next;
  logic             go_idle;

  // Next run length and hit decision for the bit currently on din.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    run_inc  = (run_len == RUN_MAX) ? RUN_MAX : run_len + RUN_ONE;
    len_next = RUN_ONE;
    hit_next = 1'b0;
    go_idle  = 1'b0;
    if (state == RUN) begin
      len_next = (din != last_bit) ? run_inc : RUN_ONE;
      if (overlap_en) begin
        hit_next = (len_next >= MIN_LEN);
      end else if (len_next == MIN_LEN) begin
        hit_next = 1'b1;
        go_idle  = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hit       <= 1'b0;
      run_len   <= '0;
      last_bit  <= 1'b0;
      hit_count <= '0;
      sticky    <= 1'b0;
    end else begin
      hit <= din_valid && hit_next;
      if (din_valid) begin
        last_bit <= din;
        run_len  <= len_next;
        state    <= go_idle ? IDLE : RUN;
      end
      // clr takes priority: a same-edge hit still pulses but is neither counted nor sticky.
      if (clr) begin
        hit_count <= '0;
        sticky    <= 1'b0;
      end else if (din_valid && hit_next) begin
        hit_count <= (hit_count == CNT_MAX) ? CNT_MAX : hit_count + CNT_W'(1);
        sticky    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alt_run_detector.sv
// Self-checking bench for alt_run_detector: table-driven vectors plus hand-written
// sequences for saturation, clr/hit collision and asynchronous reset.
module tb_alt_run_detector;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic din_valid = 1'b0;
  logic din = 1'b0;
  logic overlap_en = 1'b0;
  logic clr = 1'b0;

  logic        hit, last_bit, sticky;
  logic [7:0]  run_len;
  logic [15:0] hit_count;

  logic        s_hit, s_last_bit, s_sticky;
  logic [2:0]  s_run_len;
  logic [15:0] s_hit_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  alt_run_detector #(.MIN_RUN(3), .RUN_W(8), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .overlap_en(overlap_en), .clr(clr), .hit(hit), .run_len(run_len),
    .last_bit(last_bit), .hit_count(hit_count), .sticky(sticky)
  );

  alt_run_detector #(.MIN_RUN(3), .RUN_W(3), .CNT_W(16)) u_sat (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .overlap_en(overlap_en), .clr(clr), .hit(s_hit), .run_len(s_run_len),
    .last_bit(s_last_bit), .hit_count(s_hit_count), .sticky(s_sticky)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic        d;
    logic        ovl;
    logic        c;
    logic        e_hit;
    logic [7:0]  e_len;
    logic        e_last;
    logic [15:0] e_cnt;
    logic        e_sticky;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input logic rst, input logic valid, input logic d, input logic ovl,
                     input logic c, input logic e_hit, input logic [7:0] e_len,
                     input logic e_last, input logic [15:0] e_cnt, input logic e_sticky);
    vec_t v;
    v = '{rst, valid, d, ovl, c, e_hit, e_len, e_last, e_cnt, e_sticky};
    vecs.push_back(v);
  endtask

  // Called just after a rising edge; pulses reset without touching the clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic step(input logic valid, input logic d, input logic ovl, input logic c);
    din_valid = valid;
    din = d;
    overlap_en = ovl;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic e_hit, input logic [7:0] e_len,
                           input logic e_last, input logic [15:0] e_cnt, input logic e_sticky);
    check({tag, ".hit"}, 32'(hit), 32'(e_hit));
    check({tag, ".run_len"}, 32'(run_len), 32'(e_len));
    check({tag, ".last_bit"}, 32'(last_bit), 32'(e_last));
    check({tag, ".hit_count"}, 32'(hit_count), 32'(e_cnt));
    check({tag, ".sticky"}, 32'(sticky), 32'(e_sticky));
  endtask

  initial begin
    // rst valid din ovl clr | hit len last cnt sticky
    // Overlap mode: 0,1,0,1,1
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 2, 1, 0, 0);
    add(0, 1, 0, 1, 0, 1, 3, 0, 1, 1);
    add(0, 1, 1, 1, 0, 1, 4, 1, 2, 1);
    add(0, 1, 1, 1, 0, 0, 1, 1, 2, 1);
    // Non-overlap mode: 0,1,0,1,0,1
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 2, 1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 3, 0, 1, 1);
    add(0, 1, 1, 0, 0, 0, 1, 1, 1, 1);
    add(0, 1, 0, 0, 0, 0, 2, 0, 1, 1);
    add(0, 1, 1, 0, 0, 1, 3, 1, 2, 1);
    // Valid gaps: bits 1,0,1 with two idle cycles between (din wiggles while idle)
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0, 1, 1, 0, 0);
    add(0, 1, 0, 1, 0, 0, 2, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 2, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 2, 0, 0, 0);
    add(0, 1, 1, 1, 0, 1, 3, 1, 1, 1);
    add(0, 0, 0, 1, 0, 0, 3, 1, 1, 1);
    // Switch to non-overlap with run_len already past MIN_RUN: == never matches
    add(0, 1, 0, 0, 0, 0, 4, 0, 1, 1);
    add(0, 1, 1, 0, 0, 0, 5, 1, 1, 1);
    // clr with no hit clears count and sticky only
    add(0, 0, 0, 0, 1, 0, 5, 1, 0, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        din_valid = 1'b0;
        clr = 1'b0;
        do_reset();
      end else begin
        step(vecs[i].valid, vecs[i].d, vecs[i].ovl, vecs[i].c);
      end
      check_all($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_len, vecs[i].e_last,
                vecs[i].e_cnt, vecs[i].e_sticky);
    end

    // Saturation on the RUN_W=3 instance: 10 alternating bits in overlap mode
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, logic'(i % 2), 1'b1, 1'b0);
      check($sformatf("sat%0d.run_len", i), 32'(s_run_len), (i > 7) ? 32'd7 : 32'(i));
      check($sformatf("sat%0d.hit", i), 32'(s_hit), (i >= 3) ? 32'd1 : 32'd0);
    end
    check("sat.hit_count", 32'(s_hit_count), 32'd8);
    check("sat.sticky", 32'(s_sticky), 32'd1);

    // clr on the edge of a hit with hit_count=5
    do_reset();
    for (int i = 1; i <= 7; i++) step(1'b1, logic'(i % 2), 1'b1, 1'b0);
    check("pre_clr.hit_count", 32'(hit_count), 32'd5);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check_all("clr_hit", 1'b1, 8'd8, 1'b0, 16'd0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_all("post_clr", 1'b1, 8'd9, 1'b1, 16'd1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("post_clr_gap.hit", 32'(hit), 32'd0);

    // Asynchronous reset mid-cycle after bits 1,0
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("pre_areset.run_len", 32'(run_len), 32'd2);
    din_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check_all("areset", 1'b0, 8'd0, 1'b0, 16'd0, 1'b0);
    reset = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_all("after_areset", 1'b0, 8'd1, 1'b1, 16'd0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
